voice_allocator: RTL and testbench

Dynamic voice allocator for the tonal channels of the sound card. It accepts note-on/note-off requests over a valid/ready handshake and assigns each note to a free channel. When all channels are busy it steals the oldest voice. It drives one frequency-control byte and one gate per channel, feeding the frequency_control inputs of the tonal wave generators in place of static per-switch frequencies.

---
 rtl/voice_allocator.sv | 199 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Dynamic voice allocator: assigns note-on/off requests to tonal channels.
// Build macro VOICE_STEAL_EN: when defined, a note-on with every voice busy steals the oldest voice.
module voice_allocator #(
    parameter int VOICES = 3,
    parameter int AGE_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_on,
    input  logic [7:0]            req_freq,
    input  logic                  all_off,
    output logic [8*VOICES-1:0]   freq_bus,
    output logic [VOICES-1:0]     gate,
    output logic                  steal,
    output logic                  dropped
);

    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             lat_on;
    logic [7:0]       lat_freq;

    logic             match_hit;
    logic             free_hit;
    logic             old_hit;
    logic [IW-1:0]    match_idx;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    old_idx;
    logic [AGE_W-1:0] old_age;

    logic [7:0]       code [VOICES];
    logic [AGE_W-1:0] age  [VOICES];

    logic             cur_gate;
    logic [7:0]       cur_code;
    logic [AGE_W-1:0] cur_age;

    logic             place;
    logic             victim;
    logic             drop_now;
    logic [IW-1:0]    tgt;

    assign req_ready = (state == IDLE) && !all_off;

    assign cur_gate = gate[idx];
    assign cur_code = code[idx];
    assign cur_age  = age[idx];

    always_comb begin
        freq_bus = '0;
        for (int i = 0; i < VOICES; i++) begin
            freq_bus[8*i +: 8] = code[i];
        end
    end

    // Commit decision; the oldest voice is the fallback target.
    always_comb begin
        tgt      = old_idx;
        place    = 1'b0;
        victim   = 1'b0;
        drop_now = 1'b0;
        if (lat_on) begin
            priority case (1'b1)
                (lat_freq == 8'd0): drop_now = 1'b1;
                match_hit: begin
                    place = 1'b1;
                    tgt   = match_idx;
                end
                free_hit: begin
                    place = 1'b1;
                    tgt   = free_idx;
                end
                default: victim = 1'b1;
            endcase
        end
`ifdef VOICE_STEAL_EN
        if (victim) begin
            place = 1'b1;
        end
`else
        if (victim) begin
            drop_now = 1'b1;
        end
`endif
    end

`ifdef VOICE_STEAL_EN
    logic steal_q;
    assign steal = steal_q;
`else
    assign steal = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            lat_on    <= 1'b0;
            lat_freq  <= '0;
            match_hit <= 1'b0;
            free_hit  <= 1'b0;
            old_hit   <= 1'b0;
            match_idx <= '0;
            free_idx  <= '0;
            old_idx   <= '0;
            old_age   <= '0;
            gate      <= '0;
            dropped   <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_q   <= 1'b0;
`endif
            for (int i = 0; i < VOICES; i++) begin
                code[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            dropped <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_q <= 1'b0;
`endif
            if (all_off) begin
                state <= IDLE;
                gate  <= '0;
                for (int i = 0; i < VOICES; i++) begin
                    code[i] <= '0;
                    age[i]  <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            lat_on    <= req_on;
                            lat_freq  <= req_freq;
                            idx       <= '0;
                            match_hit <= 1'b0;
                            free_hit  <= 1'b0;
                            old_hit   <= 1'b0;
                            state     <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (cur_gate && cur_code == lat_freq && !match_hit) begin
                            match_hit <= 1'b1;
                            match_idx <= idx;
                        end
                        if (!cur_gate && !free_hit) begin
                            free_hit <= 1'b1;
                            free_idx <= idx;
                        end
                        // Strict compare keeps the lowest index on equal ages.
                        if (cur_gate && (!old_hit || cur_age > old_age)) begin
                            old_hit <= 1'b1;
                            old_idx <= idx;
                            old_age <= cur_age;
                        end
                        if (idx == LAST) begin
                            state <= COMMIT;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    COMMIT: begin
                        state   <= IDLE;
                        dropped <= drop_now;
                        if (place) begin
                            for (int i = 0; i < VOICES; i++) begin
                                if (gate[i] && age[i] != AGE_MAX) begin
                                    age[i] <= age[i] + AGE_W'(1);
                                end
                            end
                            gate[tgt] <= 1'b1;
                            code[tgt] <= lat_freq;
                            age[tgt]  <= '0;
`ifdef VOICE_STEAL_EN
                            steal_q   <= victim;
`endif
                        end else if (!lat_on && match_hit) begin
                            gate[match_idx] <= 1'b0;
                            code[match_idx] <= '0;
                            age[match_idx]  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: random note traffic against a
// whole-request reference model, plus directed all_off and async-reset cases.
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int VOICES = 3;
    localparam int AGE_W  = 4;
    localparam int AMAX   = (1 << AGE_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_on = 1'b0;
    logic [7:0]          req_freq = 8'h00;
    logic                all_off = 1'b0;
    logic [8*VOICES-1:0] freq_bus;
    logic [VOICES-1:0]   gate;
    logic                steal;
    logic                dropped;

    voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_on(req_on),
        .req_freq(req_freq),
        .all_off(all_off),
        .freq_bus(freq_bus),
        .gate(gate),
        .steal(steal),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VOICES-1:0]   gate;
        logic [8*VOICES-1:0] bus;
        bit                  steal;
        bit                  dropped;
        int                  cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   prev_ready = 1'b1;

    bit         m_gate [VOICES];
    logic [7:0] m_code [VOICES];
    int         m_age  [VOICES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < VOICES; i++) begin
            m_gate[i] = 1'b0;
            m_code[i] = 8'h00;
            m_age[i]  = 0;
        end
    endfunction

    function automatic logic [VOICES-1:0] model_gate();
        logic [VOICES-1:0] g = '0;
        for (int i = 0; i < VOICES; i++) g[i] = m_gate[i];
        return g;
    endfunction

    function automatic logic [8*VOICES-1:0] model_bus();
        logic [8*VOICES-1:0] b = '0;
        for (int i = 0; i < VOICES; i++) b[8*i +: 8] = m_gate[i] ? m_code[i] : 8'h00;
        return b;
    endfunction

    // Whole-request effect of one accepted note on the voice table.
    function automatic exp_t model_step(bit on, logic [7:0] f);
        exp_t r;
        int   match = -1;
        int   free  = -1;
        int   tgt   = -1;
        r.steal   = 1'b0;
        r.dropped = 1'b0;
        r.cyc     = 0;
        for (int i = 0; i < VOICES; i++) begin
            if (m_gate[i] && m_code[i] == f && match < 0) match = i;
            if (!m_gate[i] && free < 0) free = i;
        end
        if (on) begin
            if (f == 8'h00) r.dropped = 1'b1;
            else if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else begin
`ifdef VOICE_STEAL_EN
                for (int i = 0; i < VOICES; i++)
                    if (tgt < 0 || m_age[i] > m_age[tgt]) tgt = i;
                r.steal = 1'b1;
`else
                r.dropped = 1'b1;
`endif
            end
            if (tgt >= 0) begin
                for (int i = 0; i < VOICES; i++)
                    if (m_gate[i] && i != tgt)
                        m_age[i] = (m_age[i] < AMAX) ? m_age[i] + 1 : AMAX;
                m_gate[tgt] = 1'b1;
                m_code[tgt] = f;
                m_age[tgt]  = 0;
            end
        end else if (match >= 0) begin
            m_gate[match] = 1'b0;
            m_code[match] = 8'h00;
            m_age[match]  = 0;
        end
        r.gate = model_gate();
        r.bus  = model_bus();
        return r;
    endfunction

    // Monitor: a rising req_ready marks a finished commit.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (req_ready && !prev_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("gate", gate, e.gate);
                    chk("freq_bus", freq_bus, e.bus);
                    chk("steal", steal, e.steal);
                    chk("dropped", dropped, e.dropped);
                    chk("latency", cyc, e.cyc);
                end
            end else begin
                chk("no_pulse", {steal, dropped}, 0);
            end
        end
        prev_ready = req_ready;
    end

    task automatic issue(bit on, logic [7:0] f);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_on    = on;
        req_freq  = f;
        x = model_step(on, f);
        @(posedge clk);
        #1;
        x.cyc = cyc + VOICES + 1;
        q.push_back(x);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_gate", gate, 0);
        chk("rst_bus", freq_bus, 0);
        chk("rst_pulses", {steal, dropped}, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        issue(1'b1, 8'h40);
        issue(1'b1, 8'h50);
        issue(1'b1, 8'h60);
        issue(1'b1, 8'h70);
        issue(1'b1, 8'h50);
        issue(1'b1, 8'h11);
        issue(1'b0, 8'h50);
        issue(1'b0, 8'h99);
        issue(1'b1, 8'h33);
        issue(1'b1, 8'h00);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue($urandom_range(0, 3) != 0, 8'($urandom_range(0, 7) * 17));
        end
        wait_drain();

        // all_off during SCAN of a note-on
        mon_en = 1'b0;
        chk("pre_alloff_gate", gate, model_gate());
        req_valid = 1'b1;
        req_on    = 1'b1;
        req_freq  = 8'h21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        all_off   = 1'b1;
        req_valid = 1'b1;
        req_freq  = 8'h22;
        #1;
        chk("alloff_ready", req_ready, 0);
        @(posedge clk);
        #1;
        chk("alloff_gate", gate, 0);
        chk("alloff_bus", freq_bus, 0);
        @(negedge clk);
        chk("alloff_ready_held", req_ready, 0);
        all_off   = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < VOICES + 3; k++) begin
            @(negedge clk);
            chk("alloff_quiet", {gate, steal, dropped}, 0);
        end
        chk("alloff_idle", req_ready, 1);
        model_clear();
        mon_en = 1'b1;

        issue(1'b1, 8'h44);
        issue(1'b1, 8'h45);
        wait_drain();

        // async reset while a note-on sits in COMMIT
        mon_en = 1'b0;
        req_valid = 1'b1;
        req_on    = 1'b1;
        req_freq  = 8'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (VOICES) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_gate", gate, model_gate());
        reset = 1'b1;
        #1;
        chk("async_gate", gate, 0);
        chk("async_bus", freq_bus, 0);
        chk("async_ready", req_ready, 1);
        chk("async_pulses", {steal, dropped}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        mon_en = 1'b1;
        issue(1'b1, 8'h12);
        issue(1'b1, 8'h34);
        issue(1'b0, 8'h12);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
